// File: rtl/mpu_host_if_if.sv
// Host/TPU bus bundle for mpu_host_if: host command/data words, TPU store/load
// streams, handshake strobes and the registered transfer header/status.
interface mpu_host_if_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_TPU = 16
);
  logic              I_Req_IF;
  logic [DATA_W-1:0] I_Data_IF;
  logic              O_Vld_IF;
  logic [DATA_W-1:0] O_Data_IF;
  logic              I_Ack_MapMan;
  logic              I_Ack_ThMem;
  logic              I_No_ThMem;
  logic              I_Ack_Dispatch;
  logic              I_Commit;
  logic              O_St_Instr;
  logic [DATA_W-1:0] O_Instr;
  logic              O_Req;
  logic [DATA_W-1:0] O_Data;
  logic              I_Req;
  logic [DATA_W-1:0] I_Data;
  logic [DATA_W-1:0] O_Id;
  logic [DATA_W-1:0] O_Stride;
  logic [DATA_W-1:0] O_Base;
  logic [NUM_TPU-1:0] O_En_TPU;
  logic [4:0]        O_State;
  logic              O_Busy;

  // Host / TPU / manager side
  modport master (
    output I_Req_IF, I_Data_IF, I_Ack_MapMan, I_Ack_ThMem, I_No_ThMem,
           I_Ack_Dispatch, I_Commit, I_Req, I_Data,
    input  O_Vld_IF, O_Data_IF, O_St_Instr, O_Instr, O_Req, O_Data,
           O_Id, O_Stride, O_Base, O_En_TPU, O_State, O_Busy
  );

  // mpu_host_if side
  modport slave (
    input  I_Req_IF, I_Data_IF, I_Ack_MapMan, I_Ack_ThMem, I_No_ThMem,
           I_Ack_Dispatch, I_Commit, I_Req, I_Data,
    output O_Vld_IF, O_Data_IF, O_St_Instr, O_Instr, O_Req, O_Data,
           O_Id, O_Stride, O_Base, O_En_TPU, O_State, O_Busy
  );
endinterface

// File: rtl/mpu_host_if.sv
// MPU host interface: decodes host command words, sequences run/program/data
// transfers and tracks status. Define MPU_HOST_IF_ERR_EN for malformed-command Err.
module mpu_host_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_TPU = 16,
  parameter int LEN_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  mpu_host_if_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RUN_ID, RUN_MAP, RUN_THMEM, RUN_DISP, STOP, SET_EN, ST_PROG,
    HDR_ID, HDR_STRIDE, HDR_BASE, HDR_LEN, ST_DATA, LD_DATA
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             state, state_n;
  logic [LEN_W-1:0]   count, len;
  logic [DATA_W-1:0]  id_q, stride_q, base_q;
  logic [NUM_TPU-1:0] en_q;
  logic               ready, nothm, run, err, is_load;
  logic               set_ready, clr_ready, set_nothm, clr_nothm, set_run;
  logic               xfer, last_beat, in_data;
  logic [5:0]         cmd;

  assign cmd       = bus.I_Data_IF[5:0];
  assign in_data   = (state == ST_DATA) || (state == LD_DATA);
  assign xfer      = (state == ST_DATA) ? bus.I_Req_IF : bus.I_Req;
  assign last_beat = (count == len - ONE);

`ifdef MPU_HOST_IF_ERR_EN
  logic set_err;
`endif

  always_comb begin
    state_n   = state;
    set_ready = 1'b0;
    clr_ready = 1'b0;
    set_nothm = 1'b0;
    clr_nothm = 1'b0;
    set_run   = 1'b0;
`ifdef MPU_HOST_IF_ERR_EN
    set_err   = 1'b0;
`endif
    case (state)
      IDLE: if (bus.I_Req_IF) begin
        clr_nothm = 1'b1;
`ifdef MPU_HOST_IF_ERR_EN
        if (!$onehot(cmd)) set_err = 1'b1;
        else
`endif
        if (cmd[4]) state_n = STOP;
        else if (cmd[0]) begin state_n = RUN_ID;  clr_ready = 1'b1; end
        else if (cmd[1]) begin state_n = ST_PROG; clr_ready = 1'b1; end
        else if (cmd[2] || cmd[3]) begin state_n = HDR_ID; clr_ready = 1'b1; end
        else if (cmd[5]) state_n = SET_EN;
      end
      RUN_ID:  if (bus.I_Req_IF) state_n = RUN_MAP;
      RUN_MAP: if (bus.I_Ack_MapMan) state_n = RUN_THMEM;
      RUN_THMEM: if (bus.I_Ack_ThMem) begin
        if (bus.I_No_ThMem) begin state_n = IDLE; set_ready = 1'b1; end
        else state_n = RUN_DISP;
      end
      RUN_DISP: if (bus.I_Ack_Dispatch) begin state_n = IDLE; set_run = 1'b1; end
      STOP:     if (bus.I_Req_IF && bus.I_Data_IF[0]) state_n = RUN_DISP;
      SET_EN:   if (bus.I_Req_IF) state_n = IDLE;
      ST_PROG: if (bus.I_Ack_ThMem) begin
        state_n = IDLE;
        if (bus.I_No_ThMem) set_nothm = 1'b1;
        else                set_ready = 1'b1;
      end
      HDR_ID:     if (bus.I_Req_IF) state_n = HDR_STRIDE;
      HDR_STRIDE: if (bus.I_Req_IF) state_n = HDR_BASE;
      HDR_BASE:   if (bus.I_Req_IF) state_n = HDR_LEN;
      // Zero-length transfers complete here without a data phase
      HDR_LEN: if (bus.I_Req_IF) begin
        if (bus.I_Data_IF[LEN_W-1:0] == '0) begin state_n = IDLE; set_ready = 1'b1; end
        else state_n = is_load ? LD_DATA : ST_DATA;
      end
      ST_DATA, LD_DATA: if (xfer && last_beat) begin state_n = IDLE; set_ready = 1'b1; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      len      <= '0;
      id_q     <= '0;
      stride_q <= '0;
      base_q   <= '0;
      en_q     <= '0;
      ready    <= 1'b0;
      nothm    <= 1'b0;
      run      <= 1'b0;
      is_load  <= 1'b0;
    end else begin
      state <= state_n;
      if (clr_ready)      ready <= 1'b0;
      else if (set_ready) ready <= 1'b1;
      if (set_nothm)      nothm <= 1'b1;
      else if (clr_nothm) nothm <= 1'b0;
      if (bus.I_Commit)   run   <= 1'b0;
      else if (set_run)   run   <= 1'b1;
      // StData outranks LdData when both bits are present
      if (state == IDLE && bus.I_Req_IF) is_load <= ~cmd[2];
      if (bus.I_Req_IF) begin
        case (state)
          HDR_ID:     id_q     <= bus.I_Data_IF;
          HDR_STRIDE: stride_q <= bus.I_Data_IF;
          HDR_BASE:   base_q   <= bus.I_Data_IF;
          HDR_LEN:    len      <= bus.I_Data_IF[LEN_W-1:0];
          SET_EN:     en_q     <= bus.I_Data_IF[NUM_TPU-1:0];
          default: ;
        endcase
      end
      if (state == HDR_LEN)     count <= '0;
      else if (in_data && xfer) count <= count + ONE;
    end
  end

`ifdef MPU_HOST_IF_ERR_EN
  always_ff @(posedge clock) begin
    if (reset)        err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // Zero-latency passthroughs, forced quiet while reset is held
  assign bus.O_Req      = ~reset & (state == ST_DATA) & bus.I_Req_IF;
  assign bus.O_Data     = bus.O_Req ? bus.I_Data_IF : '0;
  assign bus.O_Vld_IF   = ~reset & (state == LD_DATA) & bus.I_Req;
  assign bus.O_Data_IF  = bus.O_Vld_IF ? bus.I_Data : '0;
  assign bus.O_St_Instr = ~reset & (state == ST_PROG) & bus.I_Req_IF;
  assign bus.O_Instr    = bus.O_St_Instr ? bus.I_Data_IF : '0;

  assign bus.O_Id     = id_q;
  assign bus.O_Stride = stride_q;
  assign bus.O_Base   = base_q;
  assign bus.O_En_TPU = en_q;
  assign bus.O_State  = {err, nothm, (state == STOP), run, ready};
  assign bus.O_Busy   = (state != IDLE);

endmodule

// File: tb/tb_mpu_host_if.sv
// Scoreboard bench for mpu_host_if: expected store/load/instruction words are
// queued as stimulus is driven and popped as the DUT strobes them out.
module tb_mpu_host_if;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] st_q[$], ld_q[$], in_q[$];

  mpu_host_if_if #(.DATA_W(32), .NUM_TPU(16)) bus();
  mpu_host_if #(.DATA_W(32), .NUM_TPU(16), .LEN_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic host(input logic [31:0] w);
    bus.I_Req_IF = 1'b1; bus.I_Data_IF = w;
    tick();
    bus.I_Req_IF = 1'b0; bus.I_Data_IF = '0;
  endtask

  task automatic host_st(input logic [31:0] w);
    st_q.push_back(w); host(w);
  endtask

  task automatic host_in(input logic [31:0] w);
    in_q.push_back(w); host(w);
  endtask

  task automatic tpu(input logic [31:0] w, input bit expect_out);
    if (expect_out) ld_q.push_back(w);
    bus.I_Req = 1'b1; bus.I_Data = w;
    tick();
    bus.I_Req = 1'b0; bus.I_Data = '0;
  endtask

  // sel: 0 MapMan, 1 ThMem, 2 ThMem+NoThMem, 3 Dispatch, 4 Commit, 5 Dispatch+Commit
  task automatic ack(input int sel);
    bus.I_Ack_MapMan   = (sel == 0);
    bus.I_Ack_ThMem    = (sel == 1) || (sel == 2);
    bus.I_No_ThMem     = (sel == 2);
    bus.I_Ack_Dispatch = (sel == 3) || (sel == 5);
    bus.I_Commit       = (sel == 4) || (sel == 5);
    tick();
    bus.I_Ack_MapMan = 0; bus.I_Ack_ThMem = 0; bus.I_No_ThMem = 0;
    bus.I_Ack_Dispatch = 0; bus.I_Commit = 0;
  endtask

  task automatic headers(input logic [31:0] cmdw, input logic [31:0] id,
                         input logic [31:0] str, input logic [31:0] base,
                         input logic [31:0] len);
    host(cmdw); host(id); host(str); host(base); host(len);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_strobes", {bus.O_Req, bus.O_Vld_IF, bus.O_St_Instr}, 0);
    end else begin
      if (bus.O_Req) begin
        chk("st_expected", st_q.size() != 0, 1);
        if (st_q.size() != 0) chk("st_data", bus.O_Data, st_q.pop_front());
      end
      if (bus.O_Vld_IF) begin
        chk("ld_expected", ld_q.size() != 0, 1);
        if (ld_q.size() != 0) chk("ld_data", bus.O_Data_IF, ld_q.pop_front());
      end
      if (bus.O_St_Instr) begin
        chk("in_expected", in_q.size() != 0, 1);
        if (in_q.size() != 0) chk("in_data", bus.O_Instr, in_q.pop_front());
      end
    end
  end

  initial begin
    bus.I_Req_IF = 0; bus.I_Data_IF = '0; bus.I_Req = 0; bus.I_Data = '0;
    bus.I_Ack_MapMan = 0; bus.I_Ack_ThMem = 0; bus.I_No_ThMem = 0;
    bus.I_Ack_Dispatch = 0; bus.I_Commit = 0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", bus.O_State, 0);
    chk("rst_busy", bus.O_Busy, 0);
    chk("rst_en", bus.O_En_TPU, 0);
    chk("rst_id", bus.O_Id, 0);

    // Store, len 3
    host(32'h04);
    chk("st_busy", bus.O_Busy, 1);
    host(32'h7); host(32'h1); host(32'h100); host(32'd3);
    host_st(32'hA); host_st(32'hB);
    chk("st_busy_mid", bus.O_Busy, 1);
    host_st(32'hC);
    chk("st_id", bus.O_Id, 32'h7);
    chk("st_stride", bus.O_Stride, 32'h1);
    chk("st_base", bus.O_Base, 32'h100);
    chk("st_ready", bus.O_State[3:0], 4'b0001);
    chk("st_idle", bus.O_Busy, 0);

    // Load, len 2; trailing TPU word after the phase must not be forwarded
    headers(32'h08, 32'h9, 32'h2, 32'h200, 32'd2);
    chk("ld_ready_clr", bus.O_State[0], 0);
    tpu(32'h55, 1); tpu(32'h66, 1);
    chk("ld_idle", bus.O_Busy, 0);
    chk("ld_ready", bus.O_State[0], 1);
    tpu(32'h77, 0);

    // Store, len 0
    host(32'h04);
    chk("z_ready_clr", bus.O_State[0], 0);
    host(32'h1); host(32'h1); host(32'h1); host(32'd0);
    chk("z_idle", bus.O_Busy, 0);
    chk("z_ready", bus.O_State[0], 1);

    // Run: stray ThMem ack in RUN_MAP is ignored
    host(32'h01); host(32'h42);
    ack(1);
    ack(0); ack(1);
    chk("run_disp_busy", bus.O_Busy, 1);
    ack(3);
    chk("run_set", bus.O_State[1], 1);
    chk("run_idle", bus.O_Busy, 0);
    host(32'h01); host(32'h43); ack(0); ack(1); ack(5);
    chk("run_clr_wins", bus.O_State[1], 0);
    host(32'h01); host(32'h44); ack(0); ack(2);
    chk("run_noth_idle", bus.O_Busy, 0);
    chk("run_noth_ready", bus.O_State[0], 1);

    // StProg with NoThMem, then cleared by next IDLE word
    host(32'h02);
    host_in(32'h1234); host_in(32'h5678);
    ack(2);
    chk("prog_noth", bus.O_State[3:0], 4'b1000);
    host(32'h00);
    chk("prog_noth_clr", bus.O_State[3:0], 4'b0000);
    chk("none_idle", bus.O_Busy, 0);
    host(32'h02); ack(1);
    chk("prog_ready", bus.O_State[3:0], 4'b0001);

    // SetEn, then hold across another command
    host(32'h20); host(32'hF00F);
    chk("en_load", bus.O_En_TPU, 16'hF00F);
    headers(32'h04, 32'h1, 32'h1, 32'h1, 32'd0);
    chk("en_hold", bus.O_En_TPU, 16'hF00F);

    // Stop: only a word with bit0 set releases it
    host(32'h10);
    chk("stop_on", bus.O_State[2], 1);
    host(32'h02);
    chk("stop_hold", bus.O_State[2], 1);
    host(32'h01);
    chk("stop_off", bus.O_State[2], 0);
    chk("stop_disp_busy", bus.O_Busy, 1);
    ack(3);
    chk("stop_run", bus.O_State[1], 1);
    ack(4);
    chk("commit_clr", bus.O_State[1], 0);

    // Multi-hot Stop+Run
    host(32'h11);
`ifdef MPU_HOST_IF_ERR_EN
    chk("mh_err", bus.O_State[4], 1);
    chk("mh_idle", bus.O_Busy, 0);
`else
    chk("mh_stop", bus.O_State[2], 1);
    host(32'h01); ack(3); ack(4);
    chk("mh_done", bus.O_Busy, 0);
`endif

    // Reset during beat 2 of a 4-beat store
    headers(32'h04, 32'h5, 32'h1, 32'h300, 32'd4);
    host_st(32'h11);
    bus.I_Req_IF = 1'b1; bus.I_Data_IF = 32'h22; reset = 1'b1;
    tick();
    reset = 1'b0; bus.I_Req_IF = 1'b0; bus.I_Data_IF = '0;
    chk("mrst_busy", bus.O_Busy, 0);
    chk("mrst_state", bus.O_State, 0);
    chk("mrst_id", bus.O_Id, 0);
    chk("mrst_en", bus.O_En_TPU, 0);
    headers(32'h04, 32'h3, 32'h1, 32'h2, 32'd1);
    host_st(32'h99);
    chk("post_rst_done", bus.O_Busy, 0);
    chk("post_rst_ready", bus.O_State[0], 1);

    host(32'h03);
`ifdef MPU_HOST_IF_ERR_EN
    chk("err_set", bus.O_State[4], 1);
    chk("err_idle", bus.O_Busy, 0);
`else
    chk("noerr_bit", bus.O_State[4], 0);
    chk("noerr_run", bus.O_Busy, 1);
`endif
    reset = 1'b1; tick(); reset = 1'b0;
    chk("end_rst_state", bus.O_State, 0);

    chk("st_q_left", st_q.size(), 0);
    chk("ld_q_left", ld_q.size(), 0);
    chk("in_q_left", in_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mpu_host_if.md
MPU_HOST_IF -- requirements
Module: mpu_host_if

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the host and TPU data words (minimum 16).
REQ-002 SHALL have parameter NUM_TPU, default 16: TPU enable width (NUM_TPU <= DATA_W).
REQ-003 SHALL have parameter LEN_W, default 16: width of the transfer-length counter (LEN_W <= DATA_W).
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- I_Req_IF  in  1  host word valid.
- I_Data_IF  in  DATA_W  host word.
- O_Vld_IF  out  1  load word valid to host.
- O_Data_IF  out  DATA_W  load word to host.
- I_Ack_MapMan, I_Ack_ThMem, I_No_ThMem, I_Ack_Dispatch, I_Commit  in  1 each  acknowledge, not-found and commit strobes.
- O_St_Instr  out  1  instruction store strobe.
- O_Instr  out  DATA_W  instruction word.
- O_Req  out  1  store word valid to TPU.
- O_Data  out  DATA_W  store word to TPU.
- I_Req  in  1  load word valid from TPU.
- I_Data  in  DATA_W  load word from TPU.
- O_Id, O_Stride, O_Base  out  DATA_W each  registered transfer header.
- O_En_TPU  out  NUM_TPU  TPU enable mask.
- O_State  out  5  {Err, NoThMem, Stop, Run, Ready}.
- O_Busy  out  1  FSM not in IDLE.

Function
REQ-005 SHALL decode command bits in IDLE when I_Req_IF=1: [0] Run, [1] StProg, [2] StData, [3] LdData, [4] Stop, [5] SetEn. Priority SHALL be Stop > Run > StProg > StData > LdData > SetEn. A word with none of these bits set SHALL leave the FSM in IDLE.
REQ-006 SHALL implement the following FSM transitions:
- Run: RUN_ID --I_Req_IF--> RUN_MAP --I_Ack_MapMan--> RUN_THMEM.
- RUN_THMEM: I_Ack_ThMem & ~I_No_ThMem goes to RUN_DISP; I_Ack_ThMem & I_No_ThMem goes to IDLE.
- RUN_DISP --I_Ack_Dispatch--> IDLE.
- Stop: STOP waits for I_Req_IF with bit[0]=1, then goes to RUN_DISP.
- SetEn: SET_EN --I_Req_IF--> IDLE.
- StProg: ST_PROG --I_Ack_ThMem--> IDLE.
- StData/LdData: HDR_ID, HDR_STRIDE, HDR_BASE, HDR_LEN, each advancing on I_Req_IF, then ST_DATA or LD_DATA.
REQ-007 In each HDR_* state, an I_Req_IF word SHALL be registered into O_Id, O_Stride, O_Base, or the length register (low LEN_W bits) respectively.
REQ-008 A length of 0 SHALL return the FSM from HDR_LEN to IDLE with no data phase and SHALL set Ready.
REQ-009 In ST_DATA, O_Req SHALL equal I_Req_IF and O_Data SHALL equal I_Data_IF combinationally (zero latency); O_Data SHALL be 0 when O_Req=0.
REQ-010 In LD_DATA, O_Vld_IF SHALL equal I_Req and O_Data_IF SHALL equal I_Data (zero latency); O_Data_IF SHALL be 0 otherwise.
REQ-011 The beat counter SHALL clear on entry to the data phase and increment per transfer. The transfer where count == len-1 SHALL end the phase: go to IDLE and set Ready on the next edge.
REQ-012 In ST_PROG, O_St_Instr SHALL equal I_Req_IF and O_Instr SHALL equal I_Data_IF (0 otherwise).
REQ-013 ST_PROG exit SHALL update status: with I_No_ThMem=1, set NoThMem; otherwise set Ready.
REQ-014 Ready SHALL be cleared on entry to RUN_ID, ST_PROG, or HDR_ID. It SHALL be set as per REQ-008, REQ-011, REQ-013, and on RUN_THMEM exit with I_No_ThMem=1. Clear SHALL win over set.
REQ-015 Run SHALL be set on RUN_DISP & I_Ack_Dispatch and cleared by I_Commit. Clear SHALL win when both occur in the same cycle.
REQ-016 NoThMem SHALL clear on any I_Req_IF in IDLE.
REQ-017 Stop SHALL be 1 exactly while the FSM is in STOP.
REQ-018 In SET_EN, I_Data_IF[NUM_TPU-1:0] SHALL be loaded into O_En_TPU; O_En_TPU SHALL hold its value otherwise.
REQ-019 Acks arriving in states that do not expect them SHALL be ignored.

Reset
REQ-020 Reset SHALL force the FSM to IDLE, mid-operation included.
REQ-021 Reset SHALL zero the counter, length, O_Id, O_Stride, O_Base, O_En_TPU and all status bits; all strobes SHALL be 0 during reset.

Configuration
REQ-022 With MPU_HOST_IF_ERR_EN defined, in IDLE a command word with zero or more than one of bits[5:0] set SHALL go to IDLE and set sticky Err (O_State[4]), cleared only by reset.
REQ-023 Without MPU_HOST_IF_ERR_EN, Err SHALL be tied to 0 and multi-hot words SHALL follow the priority of REQ-005.

Verification
REQ-024 Store, len=3: IDLE word 0x04, headers 0x7/0x1/0x100/3, data 0xA,0xB,0xC -> O_Req pulses three times with O_Data 0xA,0xB,0xC; O_Id=7; Ready=1; FSM in IDLE.
REQ-025 Load, len=2: word 0x08, headers, len 2; I_Req with 0x55 then 0x66 -> O_Vld_IF pulses twice with the same data, then IDLE; store with len=0 -> IDLE, Ready=1.
REQ-026 Run: word 0x01, ID, I_Ack_MapMan, I_Ack_ThMem, I_Ack_Dispatch -> Run=1; I_Commit and I_Ack_Dispatch in the same cycle -> Run=0.
REQ-027 StProg with I_Ack_ThMem & I_No_ThMem -> NoThMem=1; next IDLE I_Req_IF -> NoThMem=0. SetEn 0x20 then 0xF00F -> O_En_TPU=0xF00F (NUM_TPU=16).
REQ-028 Reset asserted in the second beat of a 4-beat store -> next cycle IDLE, O_Busy=0, counter=0. With ERR_EN, word 0x03 -> Err=1 and FSM in IDLE.
